// File: rtl/stepper_move_ctrl_if.sv
// Command channel between the host logic and the stepper move sequencer.
interface stepper_move_ctrl_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_steps;
  logic        cmd_dir;

  modport master (output cmd_valid, output cmd_steps, output cmd_dir, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_steps, input cmd_dir, output cmd_ready);
endinterface

// File: rtl/stepper_move_ctrl.sv
// Trapezoidal step-pulse sequencer for one stepper driver channel: relative moves,
// absolute position tracking, reduced hold current and idle driver shutdown.
module stepper_move_ctrl #(
  parameter int unsigned PERIOD_W      = 24,
  parameter int unsigned START_PERIOD  = 27000,
  parameter int unsigned MIN_PERIOD    = 2700,
  parameter int unsigned ACCEL_STEP    = 270,
  parameter int unsigned PULSE_W       = 16,
  parameter int unsigned SETTLE_CYCLES = 27000,
  parameter int unsigned HOLD_TIMEOUT  = 27000000,
  parameter logic [3:0]  RUN_VREF      = 4'd15,
  parameter logic [3:0]  HOLD_VREF     = 4'd4
) (
  input  logic                clk,
  input  logic                rst_n,
  stepper_move_ctrl_if.slave  cmd,
  input  logic                abort,
  output logic                rotate_pulse,
  output logic                direction,
  output logic                module_enable,
  output logic [3:0]          vref_level,
  output logic                busy,
  output logic                done,
  output logic signed [31:0]  position
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_RUN    = 2'd2;
  localparam logic [1:0] ST_HOLD   = 2'd3;

  localparam logic [PERIOD_W-1:0] START_P    = PERIOD_W'(START_PERIOD);
  localparam logic [PERIOD_W-1:0] MIN_P      = PERIOD_W'(MIN_PERIOD);
  localparam logic [PERIOD_W-1:0] PULSE_LAST = PERIOD_W'(PULSE_W - 1);
  localparam logic [PERIOD_W:0]   START_X    = (PERIOD_W+1)'(START_PERIOD);
  localparam logic [PERIOD_W:0]   MIN_X      = (PERIOD_W+1)'(MIN_PERIOD);
  localparam logic [PERIOD_W:0]   ACCEL_X    = (PERIOD_W+1)'(ACCEL_STEP);
  localparam logic [31:0]         SETTLE_LAST = 32'(SETTLE_CYCLES - 1);
  localparam logic [31:0]         HOLD_LAST   = 32'(HOLD_TIMEOUT - 1);

  logic [1:0]          state_q, state_d;
  logic [15:0]         remaining_q, remaining_d;
  logic [15:0]         ramp_cnt_q, ramp_cnt_d;
  logic [PERIOD_W-1:0] cur_period_q, cur_period_d;
  logic [PERIOD_W-1:0] step_timer_q, step_timer_d;
  logic [PERIOD_W-1:0] pulse_cnt_q, pulse_cnt_d;
  logic [31:0]         settle_cnt_q, settle_cnt_d;
  logic [31:0]         hold_cnt_q, hold_cnt_d;
  logic [31:0]         position_q, position_d;
  logic                rotate_pulse_q, rotate_pulse_d;
  logic                direction_q, direction_d;
  logic                module_enable_q, module_enable_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [3:0]          vref_q, vref_d;

  logic                cmd_ready_int;
  logic                accept;
  logic                step_event;
  logic [16:0]         ramp_plus1;
  logic [15:0]         rem_eff;
  logic [15:0]         rem_next;
  logic [PERIOD_W:0]   period_up;
  logic [PERIOD_W:0]   period_dn;

  assign cmd_ready_int = (state_q == ST_IDLE) || (state_q == ST_HOLD);
  assign cmd.cmd_ready = cmd_ready_int;

  always_comb begin
    accept     = cmd.cmd_valid && cmd_ready_int;
    step_event = (state_q == ST_RUN) && (step_timer_q == '0) && (remaining_q != '0);

    // An abort shortens the move to what the current ramp needs to come back down.
    ramp_plus1 = {1'b0, ramp_cnt_q} + 17'd1;
    rem_eff    = (abort && ({1'b0, remaining_q} > ramp_plus1)) ? ramp_plus1[15:0] : remaining_q;
    rem_next   = rem_eff - 16'd1;

    period_up = {1'b0, cur_period_q} + ACCEL_X;
    if (period_up > START_X) period_up = START_X;
    period_dn = {1'b0, cur_period_q} - ACCEL_X;
    if ({1'b0, cur_period_q} < (MIN_X + ACCEL_X)) period_dn = MIN_X;

    state_d      = state_q;
    remaining_d  = remaining_q;
    ramp_cnt_d   = ramp_cnt_q;
    cur_period_d = cur_period_q;
    step_timer_d = step_timer_q;
    settle_cnt_d = settle_cnt_q;
    hold_cnt_d   = hold_cnt_q;
    position_d   = position_q;
    direction_d  = direction_q;
    done_d       = 1'b0;

    case (state_q)
      ST_IDLE, ST_HOLD: begin
        if (accept) begin
          hold_cnt_d = '0;
          if (cmd.cmd_steps != '0) begin
            state_d      = ST_SETTLE;
            remaining_d  = cmd.cmd_steps;
            direction_d  = cmd.cmd_dir;
            settle_cnt_d = SETTLE_LAST;
            cur_period_d = START_P;
            ramp_cnt_d   = '0;
            step_timer_d = '0;
          end else begin
            done_d = 1'b1;
          end
        end else if (state_q == ST_HOLD) begin
          if (hold_cnt_q >= HOLD_LAST) state_d = ST_IDLE;
          else                         hold_cnt_d = hold_cnt_q + 32'd1;
        end
      end
      ST_SETTLE: begin
        if (abort) begin
          state_d    = ST_HOLD;
          done_d     = 1'b1;
          hold_cnt_d = '0;
        end else if (settle_cnt_q == '0) begin
          state_d = ST_RUN;
        end else begin
          settle_cnt_d = settle_cnt_q - 32'd1;
        end
      end
      ST_RUN: begin
        if (step_timer_q != '0) begin
          step_timer_d = step_timer_q - 1'b1;
        end else if (remaining_q == '0) begin
          state_d    = ST_HOLD;
          done_d     = 1'b1;
          hold_cnt_d = '0;
        end else begin
          if (rem_next <= ramp_cnt_q) begin
            cur_period_d = period_up[PERIOD_W-1:0];
            ramp_cnt_d   = (ramp_cnt_q == '0) ? '0 : ramp_cnt_q - 16'd1;
          end else if (cur_period_q > MIN_P) begin
            cur_period_d = period_dn[PERIOD_W-1:0];
            ramp_cnt_d   = ramp_cnt_q + 16'd1;
          end
          step_timer_d = cur_period_d - 1'b1;
          remaining_d  = rem_next;
          position_d   = direction_q ? position_q + 32'd1 : position_q - 32'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    rotate_pulse_d = step_event || (pulse_cnt_q != '0);
    if (step_event)              pulse_cnt_d = PULSE_LAST;
    else if (pulse_cnt_q != '0)  pulse_cnt_d = pulse_cnt_q - 1'b1;
    else                         pulse_cnt_d = '0;

    // Driver controls follow the next state so they line up with state_q.
    module_enable_d = (state_d != ST_IDLE);
    busy_d          = (state_d == ST_SETTLE) || (state_d == ST_RUN);
    if (busy_d)                    vref_d = RUN_VREF;
    else if (state_d == ST_HOLD)   vref_d = HOLD_VREF;
    else                           vref_d = 4'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      remaining_q     <= '0;
      ramp_cnt_q      <= '0;
      cur_period_q    <= START_P;
      step_timer_q    <= '0;
      pulse_cnt_q     <= '0;
      settle_cnt_q    <= '0;
      hold_cnt_q      <= '0;
      position_q      <= '0;
      rotate_pulse_q  <= 1'b0;
      direction_q     <= 1'b0;
      module_enable_q <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      vref_q          <= 4'd0;
    end else begin
      state_q         <= state_d;
      remaining_q     <= remaining_d;
      ramp_cnt_q      <= ramp_cnt_d;
      cur_period_q    <= cur_period_d;
      step_timer_q    <= step_timer_d;
      pulse_cnt_q     <= pulse_cnt_d;
      settle_cnt_q    <= settle_cnt_d;
      hold_cnt_q      <= hold_cnt_d;
      position_q      <= position_d;
      rotate_pulse_q  <= rotate_pulse_d;
      direction_q     <= direction_d;
      module_enable_q <= module_enable_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      vref_q          <= vref_d;
    end
  end

  assign rotate_pulse  = rotate_pulse_q;
  assign direction     = direction_q;
  assign module_enable = module_enable_q;
  assign vref_level    = vref_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign position      = position_q;

endmodule
